// File: rtl/data_mem_access_ctrl_if.sv
// Core-side request/response handshake bundle for data_mem_access_ctrl.
// The core drives the master side. The controller uses the slave side.
interface data_mem_access_ctrl_if #(
  parameter int WORD_SIZE      = 64,
  parameter int DATA_ADDR_SIZE = 8
);
  logic                        req_valid;
  logic                        req_ready;
  logic                        req_write;
  logic [DATA_ADDR_SIZE-1:0]   req_addr;
  logic [WORD_SIZE-1:0]        req_wdata;
  logic [WORD_SIZE/8-1:0]      req_bmask;
  logic                        resp_valid;
  logic                        resp_ready;
  logic                        resp_write;
  logic [WORD_SIZE-1:0]        resp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_bmask, resp_ready,
    input  req_ready, resp_valid, resp_write, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_bmask, resp_ready,
    output req_ready, resp_valid, resp_write, resp_rdata
  );
endinterface

// File: rtl/data_mem_access_ctrl.sv
// Load/store sequencer between the execute stage and data_memory, one request in flight.
// Optional byte-masked read-modify-write stores: define DATA_MEM_ACCESS_BYTE_MASK_EN.
module data_mem_access_ctrl #(
  parameter int WORD_SIZE      = 64,
  parameter int DATA_ADDR_SIZE = 8,
  parameter int MEM_RD_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  data_mem_access_ctrl_if.slave     bus,
  output logic                      mem_en,
  output logic                      mem_write,
  output logic [DATA_ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0]      mem_wdata,
  input  logic [WORD_SIZE-1:0]      mem_rdata,
  output logic                      busy
);
  localparam int         NB     = WORD_SIZE / 8;
  localparam logic [2:0] LAT_M1 = 3'(MEM_RD_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE, ST_ISSUE, LD_ISSUE, LD_WAIT, RESP
`ifdef DATA_MEM_ACCESS_BYTE_MASK_EN
    , RMW_RD, RMW_WAIT, RMW_WR
`endif
  } state_t;

  typedef struct packed {
    logic                      write;
    logic [DATA_ADDR_SIZE-1:0] addr;
    logic [WORD_SIZE-1:0]      wdata;
`ifdef DATA_MEM_ACCESS_BYTE_MASK_EN
    logic [NB-1:0]             bmask;
`endif
  } req_t;

  state_t state_q, state_d;
  req_t   req_q;
  logic [2:0] cnt_q;
  logic accept, resp_hs, issue, wr_issue, wait_st;

  assign bus.req_ready = rst_n && (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign accept        = bus.req_valid && bus.req_ready;
  assign resp_hs       = bus.resp_valid && bus.resp_ready;

`ifdef DATA_MEM_ACCESS_BYTE_MASK_EN
  logic [WORD_SIZE-1:0] merged;
  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign merged[i*8 +: 8] = req_q.bmask[i] ? req_q.wdata[i*8 +: 8] : mem_rdata[i*8 +: 8];
  end
  assign issue    = state_q inside {ST_ISSUE, LD_ISSUE, RMW_RD, RMW_WR};
  assign wr_issue = state_q inside {ST_ISSUE, RMW_WR};
  assign wait_st  = state_q inside {LD_WAIT, RMW_WAIT};
`else
  logic unused_bmask;
  assign unused_bmask = ^bus.req_bmask;
  assign issue    = state_q inside {ST_ISSUE, LD_ISSUE};
  assign wr_issue = (state_q == ST_ISSUE);
  assign wait_st  = (state_q == LD_WAIT);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) begin
        if (!bus.req_write)             state_d = LD_ISSUE;
`ifdef DATA_MEM_ACCESS_BYTE_MASK_EN
        else if (bus.req_bmask == '0)   state_d = RESP;
        else if (bus.req_bmask != '1)   state_d = RMW_RD;
`endif
        else                            state_d = ST_ISSUE;
      end
      ST_ISSUE: state_d = RESP;
      LD_ISSUE: state_d = LD_WAIT;
      LD_WAIT:  if (cnt_q == LAT_M1) state_d = RESP;
      RESP:     if (resp_hs) state_d = IDLE;
`ifdef DATA_MEM_ACCESS_BYTE_MASK_EN
      RMW_RD:   state_d = RMW_WAIT;
      RMW_WAIT: if (cnt_q == LAT_M1) state_d = RMW_WR;
      RMW_WR:   state_d = RESP;
`endif
      default:  state_d = IDLE;
    endcase
  end

  // Request latch and read-latency counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
      cnt_q <= '0;
    end else begin
      if (accept) begin
        req_q.write <= bus.req_write;
        req_q.addr  <= bus.req_addr;
        req_q.wdata <= bus.req_wdata;
`ifdef DATA_MEM_ACCESS_BYTE_MASK_EN
        req_q.bmask <= bus.req_bmask;
`endif
      end
      cnt_q <= wait_st ? cnt_q + 3'd1 : 3'd0;
    end
  end

  // Pins are registered decodes of the current state, so they trail it by one
  // cycle; the merge in RMW_WR therefore sees read data from the RMW_RD strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en         <= 1'b0;
      mem_write      <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_write <= 1'b0;
      bus.resp_rdata <= '0;
    end else begin
      mem_en    <= issue;
      mem_write <= wr_issue;
      if (issue) mem_addr <= req_q.addr;
      if (state_q == ST_ISSUE) mem_wdata <= req_q.wdata;
`ifdef DATA_MEM_ACCESS_BYTE_MASK_EN
      if (state_q == RMW_WR) mem_wdata <= merged;
`endif
      bus.resp_valid <= (state_q == RESP) && !resp_hs;
      if ((state_q == RESP) && !bus.resp_valid) begin
        bus.resp_write <= req_q.write;
        bus.resp_rdata <= req_q.write ? '0 : mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_data_mem_access_ctrl.sv
// Directed bench: two controllers (read latency 1 and 3) each driving a small memory model.
module tb_data_mem_access_ctrl;
  localparam int W = 64;
  localparam int A = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  data_mem_access_ctrl_if #(.WORD_SIZE(W), .DATA_ADDR_SIZE(A)) if0 ();
  data_mem_access_ctrl_if #(.WORD_SIZE(W), .DATA_ADDR_SIZE(A)) if3 ();

  logic         m0_en, m0_write, busy0, m3_en, m3_write, busy3;
  logic [A-1:0] m0_addr, m3_addr;
  logic [W-1:0] m0_wdata, m0_rdata, m3_wdata, m3_rdata;

  data_mem_access_ctrl #(.WORD_SIZE(W), .DATA_ADDR_SIZE(A), .MEM_RD_LATENCY(1)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(if0),
    .mem_en(m0_en), .mem_write(m0_write), .mem_addr(m0_addr),
    .mem_wdata(m0_wdata), .mem_rdata(m0_rdata), .busy(busy0));

  data_mem_access_ctrl #(.WORD_SIZE(W), .DATA_ADDR_SIZE(A), .MEM_RD_LATENCY(3)) u3 (
    .clk(clk), .rst_n(rst_n), .bus(if3),
    .mem_en(m3_en), .mem_write(m3_write), .mem_addr(m3_addr),
    .mem_wdata(m3_wdata), .mem_rdata(m3_rdata), .busy(busy3));

  // memory models: latency 1 and latency 3 synchronous reads
  logic [W-1:0] mem0 [256];
  logic [W-1:0] mem3 [256];
  logic [W-1:0] p1, p2;
  always @(posedge clk) begin
    if (m0_en && m0_write)  mem0[m0_addr] <= m0_wdata;
    if (m0_en && !m0_write) m0_rdata <= mem0[m0_addr];
  end
  always @(posedge clk) begin
    if (m3_en && m3_write)  mem3[m3_addr] <= m3_wdata;
    if (m3_en && !m3_write) p1 <= mem3[m3_addr];
    p2       <= p1;
    m3_rdata <= p2;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int sel, input logic v, input logic wr, input logic [7:0] a,
                           input logic [63:0] d, input logic [7:0] m);
    if (sel == 0) begin
      if0.req_valid = v; if0.req_write = wr; if0.req_addr = a; if0.req_wdata = d; if0.req_bmask = m;
    end else begin
      if3.req_valid = v; if3.req_write = wr; if3.req_addr = a; if3.req_wdata = d; if3.req_bmask = m;
    end
  endtask

  function automatic logic rv(input int sel);
    return (sel != 0) ? if3.resp_valid : if0.resp_valid;
  endfunction

  // One full transaction: latency in edges from accept to resp_valid, strobe count, response fields
  task automatic txn(input string tag, input int sel, input logic wr, input logic [7:0] a,
                     input logic [63:0] d, input logic [7:0] m, input int exp_lat,
                     input int exp_en, input logic [63:0] exp_rd);
    int n = 0;
    int en_cnt = 0;
    logic lw = 1'b0;
    logic [7:0] la = '0;
    logic [63:0] lwd = '0;
    drive_req(sel, 1'b1, wr, a, d, m);
    tick();
    drive_req(sel, 1'b0, 1'b0, 8'h00, 64'h0, 8'h00);
    while (!rv(sel) && n < 20) begin
      if ((sel != 0) ? m3_en : m0_en) begin
        en_cnt++;
        lw  = (sel != 0) ? m3_write : m0_write;
        la  = (sel != 0) ? m3_addr  : m0_addr;
        lwd = (sel != 0) ? m3_wdata : m0_wdata;
      end
      tick();
      n++;
    end
    chk({tag, " lat"}, n, exp_lat);
    chk({tag, " en_pulses"}, en_cnt, exp_en);
    if (en_cnt > 0) begin
      chk({tag, " mem_addr"}, la, a);
      chk({tag, " mem_write"}, lw, wr);
    end
    if (wr && exp_en == 1) chk({tag, " mem_wdata"}, lwd, d);
    chk({tag, " resp_rdata"}, (sel != 0) ? if3.resp_rdata : if0.resp_rdata, exp_rd);
    chk({tag, " resp_write"}, (sel != 0) ? if3.resp_write : if0.resp_write, wr);
    tick();
    chk({tag, " resp_done"}, rv(sel), 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_req(0, 1'b0, 1'b0, 8'h00, 64'h0, 8'h00);
    drive_req(1, 1'b0, 1'b0, 8'h00, 64'h0, 8'h00);
    if0.resp_ready = 1'b1;
    if3.resp_ready = 1'b1;
    #1;
    chk("rst mem_en", m0_en, 1'b0);
    chk("rst mem_write", m0_write, 1'b0);
    chk("rst mem_addr", m0_addr, 8'h00);
    chk("rst mem_wdata", m0_wdata, 64'h0);
    chk("rst resp_valid", if0.resp_valid, 1'b0);
    chk("rst resp_rdata", if0.resp_rdata, 64'h0);
    chk("rst resp_write", if0.resp_write, 1'b0);
    chk("rst busy", busy0, 1'b0);
    #11 rst_n = 1'b1;
    #1;
    chk("rdy after rst", if0.req_ready, 1'b1);
    tick();

    // store 67 to 0x00, cycle by cycle
    drive_req(0, 1'b1, 1'b1, 8'h00, 64'd67, 8'hFF);
    tick();
    drive_req(0, 1'b0, 1'b0, 8'h00, 64'h0, 8'h00);
    chk("st0 c0 en", m0_en, 1'b0);
    chk("st0 c0 busy", busy0, 1'b1);
    chk("st0 c0 rdy", if0.req_ready, 1'b0);
    tick();
    chk("st0 c1 en", m0_en, 1'b1);
    chk("st0 c1 wr", m0_write, 1'b1);
    chk("st0 c1 addr", m0_addr, 8'h00);
    chk("st0 c1 wdata", m0_wdata, 64'd67);
    chk("st0 c1 rv", if0.resp_valid, 1'b0);
    tick();
    chk("st0 c2 en", m0_en, 1'b0);
    chk("st0 c2 rv", if0.resp_valid, 1'b1);
    chk("st0 c2 rwrite", if0.resp_write, 1'b1);
    chk("st0 c2 rdata", if0.resp_rdata, 64'h0);
    tick();
    chk("st0 c3 rv", if0.resp_valid, 1'b0);
    chk("st0 c3 busy", busy0, 1'b0);

    txn("stFF", 0, 1'b1, 8'hFF, 64'd41, 8'hFF, 2, 1, 64'h0);
    txn("ldFF", 0, 1'b0, 8'hFF, 64'h0, 8'hFF, 3, 1, 64'd41);
    txn("ld00", 0, 1'b0, 8'h00, 64'h0, 8'hFF, 3, 1, 64'd67);

    // load with resp_ready held low; a new request waits for the handshake
    drive_req(0, 1'b1, 1'b0, 8'hFF, 64'h0, 8'hFF);
    tick();
    drive_req(0, 1'b0, 1'b0, 8'h00, 64'h0, 8'h00);
    if0.resp_ready = 1'b0;
    tick(); tick(); tick();
    chk("stall rv", if0.resp_valid, 1'b1);
    chk("stall en", m0_en, 1'b0);
    drive_req(0, 1'b1, 1'b1, 8'h10, 64'd5, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall hold rv", if0.resp_valid, 1'b1);
      chk("stall hold rdata", if0.resp_rdata, 64'd41);
      chk("stall hold rdy", if0.req_ready, 1'b0);
      chk("stall hold en", m0_en, 1'b0);
    end
    if0.resp_ready = 1'b1;
    tick();
    chk("stall hs rv", if0.resp_valid, 1'b0);
    chk("stall hs busy", busy0, 1'b0);
    chk("stall hs rdy", if0.req_ready, 1'b1);
    tick();
    drive_req(0, 1'b0, 1'b0, 8'h00, 64'h0, 8'h00);
    chk("b2b busy", busy0, 1'b1);
    tick();
    chk("b2b en", m0_en, 1'b1);
    chk("b2b addr", m0_addr, 8'h10);
    chk("b2b wdata", m0_wdata, 64'd5);
    tick();
    chk("b2b rv", if0.resp_valid, 1'b1);
    tick();
    chk("b2b done", if0.resp_valid, 1'b0);
    txn("ld10", 0, 1'b0, 8'h10, 64'h0, 8'hFF, 3, 1, 64'd5);

    // latency-3 instance
    txn("u3 st", 1, 1'b1, 8'h05, 64'h1122334455667788, 8'hFF, 2, 1, 64'h0);
    txn("u3 ld", 1, 1'b0, 8'h05, 64'h0, 8'hFF, 5, 1, 64'h1122334455667788);
    txn("u3 stFF", 1, 1'b1, 8'hFF, 64'hDEADBEEF00C0FFEE, 8'hFF, 2, 1, 64'h0);
    txn("u3 ldFF", 1, 1'b0, 8'hFF, 64'h0, 8'hFF, 5, 1, 64'hDEADBEEF00C0FFEE);

    // reset during LD_WAIT
    drive_req(0, 1'b1, 1'b0, 8'h00, 64'h0, 8'hFF);
    tick();
    drive_req(0, 1'b0, 1'b0, 8'h00, 64'h0, 8'h00);
    tick();
    chk("ldwait en", m0_en, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("abort en", m0_en, 1'b0);
    chk("abort rv", if0.resp_valid, 1'b0);
    chk("abort busy", busy0, 1'b0);
    #10 rst_n = 1'b1;
    tick();
    txn("post st", 0, 1'b1, 8'h20, 64'd99, 8'hFF, 2, 1, 64'h0);
    txn("post ld", 0, 1'b0, 8'h20, 64'h0, 8'hFF, 3, 1, 64'd99);

    // store aborted before its strobe must not write
    txn("st30", 0, 1'b1, 8'h30, 64'd12, 8'hFF, 2, 1, 64'h0);
    drive_req(0, 1'b1, 1'b1, 8'h30, 64'd77, 8'hFF);
    tick();
    drive_req(0, 1'b0, 1'b0, 8'h00, 64'h0, 8'h00);
    #3 rst_n = 1'b0;
    #1;
    chk("st abort en", m0_en, 1'b0);
    chk("st abort busy", busy0, 1'b0);
    #10 rst_n = 1'b1;
    tick();
    txn("ld30", 0, 1'b0, 8'h30, 64'h0, 8'hFF, 3, 1, 64'd12);

`ifdef DATA_MEM_ACCESS_BYTE_MASK_EN
    txn("bm base", 0, 1'b1, 8'h40, 64'h1122334455667788, 8'hFF, 2, 1, 64'h0);
    txn("bm 0F", 0, 1'b1, 8'h40, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 4, 2, 64'h0);
    txn("bm ld1", 0, 1'b0, 8'h40, 64'h0, 8'hFF, 3, 1, 64'h11223344AAAAAAAA);
    txn("bm 00", 0, 1'b1, 8'h40, 64'h5555555555555555, 8'h00, 1, 0, 64'h0);
    txn("bm ld2", 0, 1'b0, 8'h40, 64'h0, 8'hFF, 3, 1, 64'h11223344AAAAAAAA);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
